// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU sharing block.
//   W_DEF       : default operand/result width
//   alu_op_t    : ALU op code encoding
//   arb_state_t : arbiter FSM states
//   is_shift()  : op takes its shift amount from B[4:0]
//   is_legal()  : op is one of the defined ALU ops
package alu_pkg;

  localparam int unsigned W_DEF = 32;

  typedef enum logic [3:0] {
    ADD  = 4'b0000,
    SUB  = 4'b1000,
    SLL  = 4'b0001,
    SLT  = 4'b0010,
    SLTU = 4'b0011,
    XOR  = 4'b0100,
    SRL  = 4'b0101,
    SRA  = 4'b1101,
    OR   = 4'b0110,
    AND  = 4'b0111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == SLL) || (op == SRL) || (op == SRA);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    logic legal;
    case (op)
      ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND: legal = 1'b1;
      default:                                         legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational datapath ALU.
//   a_i, b_i : operands
//   op_i     : op code (alu_op_t encoding)
//   y_o      : result, 0 for undefined op codes
module alu
  import alu_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [3:0]   op_i,
  output logic [W-1:0] y_o
);

  localparam int unsigned SW = $clog2(W);

  logic [SW-1:0] shamt;
  assign shamt = b_i[SW-1:0];

  always_comb begin
    y_o = '0;
    case (op_i)
      ADD:     y_o = a_i + b_i;
      SUB:     y_o = a_i - b_i;
      SLL:     y_o = a_i << shamt;
      SLT:     y_o = {{(W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      SLTU:    y_o = {{(W-1){1'b0}}, (a_i < b_i)};
      XOR:     y_o = a_i ^ b_i;
      SRL:     y_o = a_i >> shamt;
      SRA:     y_o = $unsigned($signed(a_i) >>> shamt);
      OR:      y_o = a_i | b_i;
      AND:     y_o = a_i & b_i;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, purely combinational.
//   req_valid_i   : request valid per requester
//   last_grant_i  : requester granted most recently
//   grant_valid_o : some requester is granted
//   grant_id_o    : granted requester
module rr_arb2 (
  input  logic [1:0] req_valid_i,
  input  logic       last_grant_i,
  output logic       grant_valid_o,
  output logic       grant_id_o
);

  always_comb begin
    grant_valid_o = |req_valid_i;
    grant_id_o    = 1'b0;
    case (req_valid_i)
      2'b10:   grant_id_o = 1'b1;
      2'b11:   grant_id_o = ~last_grant_i;  // tie: whoever did not win last time
      default: grant_id_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between the execute stage (requester 0) and the
// branch/compare unit (requester 1). Round-robin arbitration, registered
// operands, registered result with valid/ready backpressure.
//   clk, rst_n          : clock, async active-low reset
//   req_valid/req_ready : per-requester handshake (bit n = requester n)
//   req0_*, req1_*      : operands and op code per requester
//   rsp_valid/rsp_ready : result handshake
//   rsp_id              : requester owning rsp_data
//   rsp_data            : ALU result
//   rsp_illegal         : op code was undefined (rsp_data forced to 0)
//   gnt_cnt0, gnt_cnt1  : saturating accepted-request counts
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [W-1:0]     req0_a,
  input  logic [W-1:0]     req0_b,
  input  logic [3:0]       req0_op,
  input  logic [W-1:0]     req1_a,
  input  logic [W-1:0]     req1_b,
  input  logic [3:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [W-1:0]     rsp_data,
  output logic             rsp_illegal,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);

  arb_state_t       state_q;
  logic             last_grant_q;
  logic [W-1:0]     a_q, b_q;
  logic [3:0]       op_q;
  logic             id_q;
  logic             rsp_valid_q, rsp_id_q, rsp_illegal_q;
  logic [W-1:0]     rsp_data_q;
  logic [CNT_W-1:0] gnt_cnt0_q, gnt_cnt1_q;

  logic             grant_valid, grant_id;
  logic             can_accept, accept;
  logic [W-1:0]     sel_a, sel_b, alu_b, alu_y;
  logic [3:0]       sel_op;

  rr_arb2 u_arb (
    .req_valid_i   (req_valid),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (grant_valid),
    .grant_id_o    (grant_id)
  );

  // A new request fits when nothing is held, or the held result leaves this cycle.
  always_comb begin
    can_accept = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
    req_ready  = 2'b00;
    if (can_accept && grant_valid) req_ready[grant_id] = 1'b1;
  end

  assign accept = |(req_valid & req_ready);
  assign sel_a  = grant_id ? req1_a  : req0_a;
  assign sel_b  = grant_id ? req1_b  : req0_b;
  assign sel_op = grant_id ? req1_op : req0_op;

  // Shifts only see B[4:0]; upper bits are cleared before the ALU.
  assign alu_b = is_shift(op_q) ? {{(W-5){1'b0}}, b_q[4:0]} : b_q;

  alu #(
    .W (W)
  ) u_alu (
    .a_i  (a_q),
    .b_i  (alu_b),
    .op_i (op_q),
    .y_o  (alu_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= '0;
      id_q          <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_data_q    <= '0;
      rsp_illegal_q <= 1'b0;
      gnt_cnt0_q    <= '0;
      gnt_cnt1_q    <= '0;
    end else begin
      if (accept) begin
        a_q          <= sel_a;
        b_q          <= sel_b;
        op_q         <= sel_op;
        id_q         <= grant_id;
        last_grant_q <= grant_id;
        if (grant_id) begin
          if (gnt_cnt1_q != '1) gnt_cnt1_q <= gnt_cnt1_q + CNT_W'(1);
        end else begin
          if (gnt_cnt0_q != '1) gnt_cnt0_q <= gnt_cnt0_q + CNT_W'(1);
        end
      end
      case (state_q)
        IDLE: begin
          if (accept) state_q <= EXEC;
        end
        EXEC: begin
          rsp_data_q    <= is_legal(op_q) ? alu_y : '0;
          rsp_illegal_q <= ~is_legal(op_q);
          rsp_id_q      <= id_q;
          rsp_valid_q   <= 1'b1;
          state_q       <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= accept ? EXEC : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_illegal = rsp_illegal_q;
  assign gnt_cnt0    = gnt_cnt0_q;
  assign gnt_cnt1    = gnt_cnt1_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  localparam int unsigned CW = 3;  // small counters so saturation is reachable

  logic          clk, rst_n;
  logic [1:0]    req_valid, req_ready;
  logic [31:0]   req0_a, req0_b, req1_a, req1_b;
  logic [3:0]    req0_op, req1_op;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_illegal;
  logic [31:0]   rsp_data;
  logic [CW-1:0] gnt_cnt0, gnt_cnt1;

  int checks = 0;
  int errors = 0;

  alu_share_arbiter #(
    .W     (32),
    .CNT_W (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_op     (req0_op),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_op     (req1_op),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .rsp_illegal (rsp_illegal),
    .gnt_cnt0    (gnt_cnt0),
    .gnt_cnt1    (gnt_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Reference model: a single result slot. A granted request computes for one
  // cycle, then its result is shown until consumed.
  logic        m_inflight, m_shown, m_last;
  logic [31:0] m_pdata, m_data;
  logic        m_pill, m_ill, m_pid, m_id;
  int          m_cnt0, m_cnt1;
  logic [1:0]  m_acc;  // requester accepted at the most recent edge

  logic [3:0] legal_ops [10] = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                                 4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_op(input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] op, output logic [31:0] r,
                                 output logic ill);
    int unsigned sh;
    sh  = b % 32;
    ill = 1'b0;
    case (op)
      4'b0000: r = a + b;
      4'b1000: r = a - b;
      4'b0001: r = a << sh;
      4'b0010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: r = (a < b) ? 32'd1 : 32'd0;
      4'b0100: r = a ^ b;
      4'b0101: r = a >> sh;
      4'b1101: r = $unsigned($signed(a) >>> sh);
      4'b0110: r = a | b;
      4'b0111: r = a & b;
      default: begin r = 32'd0; ill = 1'b1; end
    endcase
  endfunction

  task automatic model_reset();
    m_inflight = 1'b0; m_shown = 1'b0; m_last = 1'b1;
    m_pdata = '0; m_data = '0; m_pill = 1'b0; m_ill = 1'b0;
    m_pid = 1'b0; m_id = 1'b0;
    m_cnt0 = 0; m_cnt1 = 0; m_acc = 2'b00;
  endtask

  // Entered at posedge+1 with inputs already driven; returns at next posedge+1.
  task automatic cycle();
    int          g;
    logic        free;
    logic [1:0]  exp_ready;
    logic [31:0] r;
    logic        il;
    #1;
    g = -1;
    if (req_valid == 2'b11) g = m_last ? 0 : 1;
    else if (req_valid[0])  g = 0;
    else if (req_valid[1])  g = 1;
    free      = !m_inflight && (!m_shown || rsp_ready);
    exp_ready = (free && g >= 0) ? (2'b01 << g) : 2'b00;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("rsp_valid", 32'(rsp_valid), 32'(m_shown));
    if (m_shown) begin
      check("rsp_id", 32'(rsp_id), 32'(m_id));
      check("rsp_data", rsp_data, m_data);
      check("rsp_illegal", 32'(rsp_illegal), 32'(m_ill));
    end
    check("gnt_cnt0", 32'(gnt_cnt0), m_cnt0);
    check("gnt_cnt1", 32'(gnt_cnt1), m_cnt1);
    if (g == 1) ref_op(req1_a, req1_b, req1_op, r, il);
    else        ref_op(req0_a, req0_b, req0_op, r, il);
    @(posedge clk);
    if (m_inflight) begin
      m_shown = 1'b1; m_data = m_pdata; m_ill = m_pill; m_id = m_pid;
      m_inflight = 1'b0;
    end else if (m_shown && rsp_ready) begin
      m_shown = 1'b0;
    end
    m_acc = exp_ready;
    if (exp_ready != 2'b00) begin
      m_inflight = 1'b1;
      m_pdata = r; m_pill = il; m_pid = (g == 1);
      m_last = (g == 1);
      if (g == 1) m_cnt1 = (m_cnt1 < 7) ? m_cnt1 + 1 : m_cnt1;
      else        m_cnt0 = (m_cnt0 < 7) ? m_cnt0 + 1 : m_cnt0;
    end
    #1;
  endtask

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op);
    if (id == 0) begin req0_a = a; req0_b = b; req0_op = op; req_valid[0] = 1'b1; end
    else         begin req1_a = a; req1_b = b; req1_op = op; req_valid[1] = 1'b1; end
  endtask

  // Issue one request and run until its result is shown; checks the 2-cycle latency.
  task automatic run_one(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op);
    int n;
    logic ok;
    set_req(id, a, b, op);
    ok = 1'b0;
    n = 0;
    while (!ok && n < 10) begin
      cycle();
      ok = m_acc[id];
      n++;
    end
    check("accept_timeout", 32'(ok), 32'd1);
    req_valid[id] = 1'b0;
    n = 1;
    while (!m_shown && n < 10) begin
      cycle();
      n++;
    end
    check("latency", n, 2);
  endtask

  task automatic rand_req(input int id);
    logic [31:0] a, b;
    logic [3:0]  op;
    if (req_valid[id] && !m_acc[id]) begin
      if ($urandom_range(0, 19) == 0) req_valid[id] = 1'b0;  // occasional withdrawal
    end else begin
      a  = $urandom;
      b  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
      op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                        : legal_ops[$urandom_range(0, 9)];
      set_req(id, a, b, op);
      req_valid[id] = ($urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    logic prev_g, have_prev;
    int   k;

    rst_n = 1'b0;
    req_valid = 2'b00; rsp_ready = 1'b1;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    model_reset();
    #12;
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_rsp_data", rsp_data, 32'd0);
    check("reset_rsp_illegal", 32'(rsp_illegal), 32'd0);
    check("reset_cnt0", 32'(gnt_cnt0), 32'd0);
    check("reset_cnt1", 32'(gnt_cnt1), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Requester 0 alone: 5 + 7
    run_one(0, 32'd5, 32'd7, 4'b0000);
    check("add_data", rsp_data, 32'd12);
    check("add_id", 32'(rsp_id), 32'd0);
    check("add_cnt0", 32'(gnt_cnt0), 32'd1);

    // Both valid continuously: grants alternate; r1 compares
    set_req(0, 32'd100, 32'd1, 4'b0000);
    set_req(1, 32'hFFFF_FFFF, 32'd1, 4'b0010);
    have_prev = 1'b0; prev_g = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) req1_op = 4'b0011;
      cycle();
      if (m_acc != 2'b00) begin
        if (have_prev) check("alternate", 32'(m_acc[1]), 32'(!prev_g));
        prev_g = m_acc[1];
        have_prev = 1'b1;
      end
      if (m_shown && m_id && i < 8) check("slt_data", rsp_data, 32'd1);
      if (m_shown && m_id && i >= 12) check("sltu_data", rsp_data, 32'd0);
    end
    req_valid = 2'b00;
    cycle(); cycle();

    // Shifts use only B[4:0]
    run_one(0, 32'h8000_0000, 32'h0000_0021, 4'b1101);
    check("sra_data", rsp_data, 32'hC000_0000);
    run_one(0, 32'h8000_0000, 32'h0000_0021, 4'b0001);
    check("sll_data", rsp_data, 32'h0000_0000);

    // Result stall
    run_one(0, 32'd3, 32'd4, 4'b0100);
    rsp_ready = 1'b0;
    set_req(1, 32'd20, 32'd5, 4'b1000);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("stall_data", rsp_data, 32'd7);
      check("stall_id", 32'(rsp_id), 32'd0);
      check("stall_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    check("release_ready", 32'(req_ready), 32'd2);
    cycle();
    req_valid = 2'b00;
    cycle();
    check("release_data", rsp_data, 32'd15);
    check("release_id", 32'(rsp_id), 32'd1);

    // Illegal op then a legal one
    run_one(0, 32'd1, 32'd2, 4'b1111);
    check("illegal_data", rsp_data, 32'd0);
    check("illegal_flag", 32'(rsp_illegal), 32'd1);
    run_one(1, 32'd1, 32'd2, 4'b0000);
    check("legal_flag", 32'(rsp_illegal), 32'd0);
    check("legal_data", rsp_data, 32'd3);

    // Reset during EXEC
    set_req(0, 32'd9, 32'd9, 4'b0000);
    k = 0;
    m_acc = 2'b00;
    while (!m_acc[0] && k < 10) begin
      cycle();
      k++;
    end
    check("exec_accept", 32'(m_acc[0]), 32'd1);
    req_valid = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_illegal", 32'(rsp_illegal), 32'd0);
    check("rst_cnt0", 32'(gnt_cnt0), 32'd0);
    check("rst_cnt1", 32'(gnt_cnt1), 32'd0);
    #2 rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    set_req(0, 32'd1, 32'd1, 4'b0000);
    set_req(1, 32'd2, 32'd2, 4'b0000);
    #1;
    check("post_rst_tie", 32'(req_ready), 32'd1);
    cycle();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      rand_req(0);
      rand_req(1);
      cycle();
    end
    check("sat_cnt0", 32'(gnt_cnt0), 32'd7);
    check("sat_cnt1", 32'(gnt_cnt1), 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
